// File: rtl/l2_adapter_pkg.sv
// Shared types and constants for the L2 line <-> memory burst adapter.
// A cache line is always BEATS memory beats wide.
package l2_adapter_pkg;

  localparam int BEATS   = 4;
  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Memory transfers are line aligned: drop the 32-byte offset bits.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide buffer split into beats: whole-line load for evictions,
// per-beat write for read bursts, and a beat read mux for write bursts.
module line_beat_buffer
  import l2_adapter_pkg::*;
#(
  parameter int s_line  = S_LINE,
  parameter int s_burst = S_BURST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_line,
  input  logic [s_line-1:0]  line_in,
  input  logic               beat_we,
  input  logic [1:0]         beat_sel,
  input  logic [s_burst-1:0] beat_in,
  output logic [s_line-1:0]  line_out,
  output logic [s_burst-1:0] beat_out
);

  logic [s_burst-1:0] beat_r [BEATS];
  logic [BEATS-1:0]   beat_sel_s;

  // One-hot beat write-select, only while a beat is being stored.
  always_comb begin
    beat_sel_s = 4'b0000;
    if (beat_we) begin
      case (beat_sel)
        2'd0:    beat_sel_s = 4'b0001;
        2'd1:    beat_sel_s = 4'b0010;
        2'd2:    beat_sel_s = 4'b0100;
        2'd3:    beat_sel_s = 4'b1000;
        default: beat_sel_s = 4'b0000;
      endcase
    end else begin
      beat_sel_s = 4'b0000;
    end
  end

  // Beat storage: a line load takes priority over a single-beat write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < BEATS; k++) beat_r[k] <= '0;
    end else if (load_line) begin
      for (int k = 0; k < BEATS; k++) beat_r[k] <= line_in[k*s_burst +: s_burst];
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_sel_s[k]) beat_r[k] <= beat_in;
      end
    end
  end

  // Line view of the beats, beat 0 in the least significant bits.
  always_comb begin
    line_out = '0;
    for (int k = 0; k < BEATS; k++) line_out[k*s_burst +: s_burst] = beat_r[k];
  end

  // Outgoing beat selected by the current beat count.
  always_comb begin
    case (beat_sel)
      2'd0:    beat_out = beat_r[0];
      2'd1:    beat_out = beat_r[1];
      2'd2:    beat_out = beat_r[2];
      2'd3:    beat_out = beat_r[3];
      default: beat_out = beat_r[0];
    endcase
  end

endmodule

// File: rtl/l2_line_adapter.sv
// Converts L2 whole-line read/write requests into four-beat memory bursts,
// with wait states on resp_i and a one-cycle completion pulse back to the L2.
module l2_line_adapter
  import l2_adapter_pkg::*;
#(
  parameter int s_line  = S_LINE,
  parameter int s_burst = S_BURST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [s_burst-1:0] burst_o,
  input  logic [s_burst-1:0] burst_i,
  input  logic               resp_i
);

  state_e      state_r, state_s;
  logic [1:0]  beat_r, beat_s;
  logic [31:0] addr_r;
  logic        accept_rd_s, accept_wr_s, beat_done_s, rd_beat_s;

  // Next state and beat count; read wins over write when both are requested.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    accept_rd_s = 1'b0;
    accept_wr_s = 1'b0;
    beat_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (read_i) begin
          state_s     = RD_BURST;
          accept_rd_s = 1'b1;
        end else if (write_i) begin
          state_s     = WR_BURST;
          accept_wr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RD_BURST, WR_BURST: begin
        if (resp_i) begin
          beat_done_s = 1'b1;
          if (beat_r == 2'd3) begin
            state_s = DONE;
            beat_s  = 2'd0;
          end else begin
            beat_s = beat_r + 2'd1;
          end
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, beat count and latched line address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      beat_r  <= 2'd0;
      addr_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      if (accept_rd_s || accept_wr_s) addr_r <= line_align(address_i);
    end
  end

  assign rd_beat_s = beat_done_s && (state_r == RD_BURST);

  line_beat_buffer #(
    .s_line  (s_line),
    .s_burst (s_burst)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .load_line (accept_wr_s),
    .line_in   (line_i),
    .beat_we   (rd_beat_s),
    .beat_sel  (beat_r),
    .beat_in   (burst_i),
    .line_out  (line_o),
    .beat_out  (burst_o)
  );

  // Request and completion strobes are pure decodes of the state register.
  assign read_o    = (state_r == RD_BURST);
  assign write_o   = (state_r == WR_BURST);
  assign resp_o    = (state_r == DONE);
  assign address_o = addr_r;

endmodule

// File: tb/tb_l2_line_adapter.sv
// Self-checking bench for l2_line_adapter: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_l2_line_adapter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  address_i = 32'd0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = 256'd0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = 64'd0;
  logic         resp_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  l2_line_adapter dut (
    .clk(clk), .reset(reset), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, counted in completed beats.
  bit          m_busy = 1'b0;
  bit          m_rd   = 1'b0;
  bit          m_done = 1'b0;
  int          m_beats = 0;
  logic [31:0] m_addr = 32'd0;
  logic [63:0] m_line [4] = '{default: 64'd0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_rd <= 1'b0; m_done <= 1'b0; m_beats <= 0; m_addr <= 32'd0;
      for (int i = 0; i < 4; i++) m_line[i] <= 64'd0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_busy) begin
      if (read_i) begin
        m_busy <= 1'b1; m_rd <= 1'b1; m_addr <= {address_i[31:5], 5'd0};
      end else if (write_i) begin
        m_busy <= 1'b1; m_rd <= 1'b0; m_addr <= {address_i[31:5], 5'd0};
        for (int i = 0; i < 4; i++) m_line[i] <= line_i[64*i +: 64];
      end
    end else if (resp_i) begin
      if (m_rd) m_line[m_beats] <= burst_i;
      if (m_beats == 3) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_beats <= 0;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("read_o", read_o, m_busy && m_rd);
    chk("write_o", write_o, m_busy && !m_rd);
    chk("resp_o", resp_o, m_done);
    chk("address_o", address_o, m_addr);
    if (m_busy && !m_rd) chk("burst_o", burst_o, m_line[m_beats]);
    if (m_done && m_rd) chk("line_o", line_o, {m_line[3], m_line[2], m_line[1], m_line[0]});
  end

  task automatic run_read(input logic [31:0] addr, input logic [255:0] data,
                          input int stall_from, input int stall_to,
                          output int resp_cyc, output int rd_cycles);
    int k;
    k = 0; resp_cyc = -1; rd_cycles = 0;
    @(posedge clk); #1;
    address_i = addr; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b1;
    for (int c = 1; c <= 20 && resp_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c >= stall_from && c <= stall_to) begin
        resp_i = 1'b0; burst_i = {$urandom, $urandom};
      end else begin
        resp_i = 1'b1;
        burst_i = (k < 4) ? data[64*k +: 64] : {$urandom, $urandom};
        k++;
      end
      #1;
      if (read_o) rd_cycles++;
      if (resp_o) begin resp_cyc = c; read_i = 1'b0; end
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] data,
                           output int resp_cyc, output int wr_cycles);
    resp_cyc = -1; wr_cycles = 0;
    @(posedge clk); #1;
    address_i = addr; write_i = 1'b1; read_i = 1'b0; resp_i = 1'b1; line_i = data;
    for (int c = 1; c <= 20 && resp_cyc < 0; c++) begin
      @(posedge clk); #1;
      line_i = {8{$urandom}};
      #1;
      if (write_o) begin
        if (wr_cycles < 4) chk("write_beat", burst_o, data[64*wr_cycles +: 64]);
        wr_cycles++;
      end
      if (resp_o) begin resp_cyc = c; write_i = 1'b0; end
    end
  endtask

  initial begin
    int rc, cyc, r1, r2, wr_early;
    logic [255:0] rdata;
    rdata = {64'h4444444444444444, 64'h3333333333333333,
             64'h2222222222222222, 64'h1111111111111111};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", address_o, 32'd0);
    chk("rst_line_o", line_o, 256'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Plain read, memory never stalls.
    run_read(32'h0000_1234, rdata, 0, -1, rc, cyc);
    chk("rd_resp_cycle", rc, 5);
    chk("rd_read_cycles", cyc, 4);
    chk("rd_address", address_o, 32'h0000_1220);
    chk("rd_line", line_o, rdata);

    // Eviction, line_i scrambled after acceptance.
    run_write(32'h0000_ABCD, {8{32'hDEADBEEF}}, rc, cyc);
    chk("wr_resp_cycle", rc, 5);
    chk("wr_write_cycles", cyc, 4);
    chk("wr_address", address_o, 32'h0000_ABC0);

    // Read with two wait states.
    run_read(32'h8000_003F, rdata, 2, 3, rc, cyc);
    chk("stall_resp_cycle", rc, 7);
    chk("stall_read_cycles", cyc, 6);
    chk("stall_line", line_o, rdata);

    // Read and write together: read first, write after one IDLE cycle.
    r1 = -1; r2 = -1; wr_early = 0;
    @(posedge clk); #1;
    address_i = 32'h0000_0100; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
    line_i = {4{64'h0123456789ABCDEF}};
    for (int c = 1; c <= 30 && r2 < 0; c++) begin
      @(posedge clk); #1;
      burst_i = {$urandom, $urandom};
      #1;
      if (c == 1) chk("both_read_first", {read_o, write_o}, 2'b10);
      if (r1 < 0 && write_o) wr_early++;
      if (c == 6) chk("both_idle_gap", {read_o, write_o, resp_o}, 3'b000);
      if (resp_o) begin
        if (r1 < 0) begin r1 = c; read_i = 1'b0; end
        else begin r2 = c; write_i = 1'b0; end
      end
    end
    chk("both_no_early_write", wr_early, 0);
    chk("both_first_resp", r1, 5);
    chk("both_second_resp", r2, 11);

    // Asynchronous reset in the middle of a write burst.
    @(posedge clk); #1;
    address_i = 32'h0000_2000; write_i = 1'b1; resp_i = 1'b1; line_i = {8{32'hCAFEF00D}};
    repeat (3) @(posedge clk);
    #1;
    write_i = 1'b0; reset = 1'b0;
    #1;
    chk("arst_outputs", {read_o, write_o, resp_o}, 3'b000);
    chk("arst_address", address_o, 32'd0);
    chk("arst_line", line_o, 256'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk("post_rst_no_write", {read_o, write_o}, 2'b00);
    end

    // Random traffic, random wait states and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      read_i    = ($urandom_range(0, 3) == 0);
      write_i   = ($urandom_range(0, 3) == 0);
      resp_i    = ($urandom_range(0, 3) != 0);
      address_i = $urandom;
      burst_i   = {$urandom, $urandom};
      for (int w = 0; w < 8; w++) line_i[32*w +: 32] = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0; #2; reset = 1'b1;
      end
    end
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
